csw_tape_player: RTL
====================

Name: csw_tape_player

Overview:
- Plays a CSW-1 (RLE) tape image held in SDRAM and produces the cassette input level for the motherboard's `tape_in`.
- Fetches image bytes over a req/ack memory handshake into a small prefetch FIFO.
- Decodes each byte into a pulse length and toggles the level at sample-rate ticks derived from `ce_16`.
- Playback runs only while the PPI tape motor bit and the user play control are both high.

Parameters:
- SAMPLE_DIV, 363, `ce_16` pulses per CSW sample (16 MHz / 44.1 kHz).
- ADDR_W, 24, width of the image byte address and size.
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_16  in  1  16 MHz clock enable
- play  in  1  user play control; 0 = pause
- motor  in  1  PPI port C bit 4 (`tape_motor`)
- restart  in  1  one-clk pulse: rewind to byte 0
- tape_size  in  ADDR_W  image length in bytes; 0 = no tape
- rd_req  out  1  memory read request
- rd_addr  out  ADDR_W  byte address of the request
- rd_ack  in  1  one-clk strobe; `rd_data` is valid in this cycle
- rd_data  in  8  byte returned
- tape_level  out  1  cassette level, goes to `tape_in`
- active  out  1  decoder is in RUN and not paused
- done  out  1  image fully played

Behaviour:
- Reset and restart values: `tape_level`=0, `rd_req`=0, `rd_addr`=0, `done`=0, `active`=0, FIFO empty, FSM in LOAD, tick divider=0. `restart` has the same effect as `reset` and wins over all simultaneous events.
- Fetcher request rule: assert `rd_req` when `rd_req`=0, FIFO not full (counting the outstanding entry), `rd_addr` < `tape_size`, and neither reset nor restart is active.
- Fetcher hold and completion: hold `rd_req` and `rd_addr` stable until `rd_ack`. On `rd_ack` with `rd_req`=1: push `rd_data`, `rd_addr`+1, drop `rd_req` in the same edge. The next request can issue one clk later at the earliest.
- Stray acks: `rd_ack` while `rd_req`=0 is ignored, including a late ack arriving after reset or restart.
- The fetcher ignores `play` and `motor`, so the FIFO keeps filling while paused.
- FIFO: push and pop in the same clk are both performed and the count is unchanged. Pop never happens when empty; push never happens when full (guaranteed by the request rule).
- Tick: `tick` = `ce_16` & `play` & `motor` & (divider==SAMPLE_DIV-1). The divider advances only on `ce_16` while `play` & `motor`, wraps to 0 on tick, and holds its value while paused.
- FSM states: LOAD, EXT0, EXT1, EXT2, EXT3, RUN, END.
- LOAD, FIFO empty, `rd_addr`==`tape_size`, no request outstanding: go to END.
- LOAD, FIFO empty otherwise: stay in LOAD. No tick is consumed and `tape_level` holds.
- LOAD, FIFO non-empty: pop. A nonzero byte b sets `cnt`=b and goes to RUN. A byte 0x00 goes to EXT0.
- EXT0..EXT3: each pops one byte when available and assembles 32-bit `cnt`, little-endian, EXT0 = bits 7:0.
- After EXT3: `cnt`==0 returns to LOAD with no toggle. Otherwise go to RUN.
- An image that ends inside EXT0..EXT3 goes to END with no toggle.
- RUN: on tick, `cnt`-1. A tick with `cnt`==1 toggles `tape_level` in the same edge and goes to LOAD. A pulse of n samples therefore lasts exactly n ticks.
- END: `done`=1, `tape_level` holds, `active`=0. Leaves END only on reset or restart.
- `active` = (state==RUN) & `play` & `motor`, registered one clk.
- `tape_size` is sampled only via the fetcher compare. Software changes it only while `restart` is held.

Decomposition:
- Package `csw_tape_pkg`:
  - state enum `csw_state_t`
  - constant `CSW_EXT_MARKER` = 8'h00
  - constant `CSW_CNT_W` = 32
- Sub-module `tape_byte_fifo`: synchronous FIFO with parameters DEPTH and width 8, ports push/pop/din/dout/full/empty/count.
- The fetcher, tick divider and FSM stay in `csw_tape_player`.

Test Plan (bench uses SAMPLE_DIV=4 and `ce_16` held at 1):
- Image {03,02}, `play`=`motor`=1, ack 2 clk after req → `tape_level` rises after 12 clk of ticks (3×4). It falls 8 clk later. `done`=1 once the FIFO is empty and `rd_addr`=2.
- Image {00,05,00,00,00} → single pulse of 5 ticks (20 clk), then `done`. Image {00,00,00,00,00,01} → the zero-length extended pulse is skipped and the level toggles after 1 tick.
- Drop `motor` mid-pulse of byte 0x10 for 50 clk → divider and `cnt` freeze, `active`=0, and the fetcher still fills 4 FIFO entries. The pulse completes 16 total ticks after resume.
- Ack latency of 40 clk with 1-sample pulses → LOAD stalls while the FIFO is empty, no toggle is lost or duplicated, and `rd_addr` increments exactly once per ack.
- `restart` asserted while `rd_req`=1, ack arrives the next clk → ack ignored. `rd_addr`=0, FIFO empty, `tape_level`=0, replay identical to the first run.
- `tape_size`=0 → no `rd_req` ever. FSM reaches END within 2 clk with `done`=1 and `tape_level`=0.

Source files
------------

// File: rtl/csw_tape_pkg.sv
// Shared types and constants for the CSW-1 tape player.
//   csw_state_t    : decoder FSM states
//   CSW_EXT_MARKER : RLE byte that introduces a 32-bit extended pulse length
//   CSW_CNT_W      : width of the pulse length counter
package csw_tape_pkg;

  localparam int unsigned CSW_CNT_W      = 32;
  localparam logic [7:0]  CSW_EXT_MARKER = 8'h00;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_EXT0,
    ST_EXT1,
    ST_EXT2,
    ST_EXT3,
    ST_RUN,
    ST_END
  } csw_state_t;

endpackage

// File: rtl/tape_byte_fifo.sv
// Small synchronous byte FIFO with first-word fall-through output.
//   clk, reset : clock, synchronous active-high clear
//   push, din  : write din when push
//   pop, dout  : dout shows the oldest entry; pop discards it
//   full, empty, count : occupancy status
module tape_byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/csw_tape_player.sv
// CSW-1 (RLE) tape image player: fetches image bytes from memory into a
// prefetch FIFO, decodes pulse lengths and toggles the cassette level at
// sample-rate ticks derived from ce_16.
//   clk, reset, ce_16       : clock, sync reset, 16 MHz enable
//   play, motor             : playback runs only while both are high
//   restart                 : one-clk rewind to byte 0 (same effect as reset)
//   tape_size               : image length in bytes, 0 = no tape
//   rd_req/rd_addr/rd_ack/rd_data : byte read handshake
//   tape_level, active, done: cassette level and status
module csw_tape_player
  import csw_tape_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 363,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_16,
  input  logic              play,
  input  logic              motor,
  input  logic              restart,
  input  logic [ADDR_W-1:0] tape_size,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              tape_level,
  output logic              active,
  output logic              done
);

  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              clr_c;
  logic              push_c;
  logic              pop_c;
  logic              room_c;
  logic              tick_c;
  logic              img_end_c;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [DIV_W-1:0]  div;
  logic [CSW_CNT_W-1:0] cnt;
  csw_state_t        state;

  // Restart behaves exactly like reset and overrides everything else.
  assign clr_c = reset | restart;

  // Only an ack that answers an outstanding request is accepted.
  assign push_c = rd_req & rd_ack & ~fifo_full & ~clr_c;

  // Room check includes the entry that an outstanding request will deliver.
  assign room_c = (fifo_count + FCNT_W'(rd_req)) < FCNT_W'(FIFO_DEPTH);

  // The image is exhausted once every byte has been requested and delivered.
  assign img_end_c = (rd_addr == tape_size) & ~rd_req;

  assign pop_c = ~clr_c & ~fifo_empty &
                 (state inside {ST_LOAD, ST_EXT0, ST_EXT1, ST_EXT2, ST_EXT3});

  assign tick_c = ce_16 & play & motor & (div == DIV_W'(SAMPLE_DIV - 1));

  tape_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (clr_c),
    .push  (push_c),
    .pop   (pop_c),
    .din   (rd_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetcher: one outstanding request at a time, independent of play/motor.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      rd_req  <= 1'b0;
      rd_addr <= '0;
    end else if (rd_req) begin
      if (rd_ack) begin
        rd_req  <= 1'b0;
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end else if (room_c && (rd_addr < tape_size)) begin
      rd_req <= 1'b1;
    end
  end

  // Sample-rate divider; frozen while paused.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      div <= '0;
    end else if (ce_16 && play && motor) begin
      div <= tick_c ? '0 : div + DIV_W'(1);
    end
  end

  // Decoder FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (clr_c) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      tape_level <= 1'b0;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      active <= (state == ST_RUN) & play & motor;
      case (state)
        ST_LOAD: begin
          if (!fifo_empty) begin
            if (fifo_dout != CSW_EXT_MARKER) begin
              cnt   <= CSW_CNT_W'(fifo_dout);
              state <= ST_RUN;
            end else begin
              state <= ST_EXT0;
            end
          end else if (img_end_c) begin
            state <= ST_END;
            done  <= 1'b1;
          end
        end
        ST_EXT0, ST_EXT1, ST_EXT2: begin
          if (!fifo_empty) begin
            case (state)
              ST_EXT0: begin
                cnt   <= CSW_CNT_W'(fifo_dout);
                state <= ST_EXT1;
              end
              ST_EXT1: begin
                cnt[15:8] <= fifo_dout;
                state     <= ST_EXT2;
              end
              default: begin
                cnt[23:16] <= fifo_dout;
                state      <= ST_EXT3;
              end
            endcase
          end else if (img_end_c) begin
            state <= ST_END;
            done  <= 1'b1;
          end
        end
        ST_EXT3: begin
          if (!fifo_empty) begin
            cnt[31:24] <= fifo_dout;
            // A zero-length extended pulse is skipped without a toggle.
            state <= ({fifo_dout, cnt[23:0]} == '0) ? ST_LOAD : ST_RUN;
          end else if (img_end_c) begin
            state <= ST_END;
            done  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick_c) begin
            cnt <= cnt - CSW_CNT_W'(1);
            if (cnt == CSW_CNT_W'(1)) begin
              tape_level <= ~tape_level;
              state      <= ST_LOAD;
            end
          end
        end
        ST_END: begin
          done <= 1'b1;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
